// File: rtl/axis_frame_trailer.sv
// Forwards a 64-bit AXIS stream through one register stage and appends a trailer
// word (magic, sequence number, truncation flag, word count) after every frame.
module axis_frame_trailer #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned MAX_LEN       = 4096,
    parameter logic [15:0] TRAILER_MAGIC = 16'hFEED
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  frame_done,
    output logic [15:0]           trunc_count
);

    localparam int unsigned CNT_W = 31;

    typedef enum logic {
        PASS  = 1'b0,
        TRAIL = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  r_trunc;
    logic                  w_trunc_nxt;
    logic                  r_m_valid;
    logic                  w_valid_nxt;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  r_m_last;
    logic                  w_last_nxt;
    logic [15:0]           r_seq;
    logic [15:0]           r_trunc_cnt;
    logic                  w_out_free;
    logic                  w_s_ready;
    logic                  w_at_max;
    logic                  w_trailer_hs;
    logic [DATA_WIDTH-1:0] w_trailer;

    assign w_out_free   = !r_m_valid || m_axis_tready;
    assign w_trailer_hs = r_m_valid && m_axis_tready && r_m_last;
    assign w_cnt_inc    = r_cnt + CNT_W'(1);
    assign w_at_max     = (w_cnt_inc == CNT_W'(MAX_LEN));
    assign w_trailer    = DATA_WIDTH'({TRAILER_MAGIC, r_seq, r_trunc, r_cnt});

    // Next-state and output-register load decisions
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_trunc_nxt = r_trunc;
        w_valid_nxt = r_m_valid && !m_axis_tready;
        w_data_nxt  = r_m_data;
        w_last_nxt  = r_m_last;
        w_s_ready   = 1'b0;
        case (r_state)
            PASS: begin
                w_s_ready = w_out_free;
                if (s_axis_tvalid && w_out_free) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = s_axis_tdata;
                    w_last_nxt  = 1'b0;
                    w_cnt_nxt   = w_cnt_inc;
                    if (s_axis_tlast || w_at_max) begin
                        w_trunc_nxt = w_at_max && !s_axis_tlast;
                        w_state_nxt = TRAIL;
                    end
                end
            end
            TRAIL: begin
                if (w_out_free) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = w_trailer;
                    w_last_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = PASS;
                end
            end
            default: w_state_nxt = PASS;
        endcase
    end

    // The trunc flag of the trailer being handed off lives in its own bit 31
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= PASS;
            r_cnt       <= '0;
            r_trunc     <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_last    <= 1'b0;
            r_seq       <= '0;
            r_trunc_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_trunc   <= w_trunc_nxt;
            r_m_valid <= w_valid_nxt;
            r_m_data  <= w_data_nxt;
            r_m_last  <= w_last_nxt;
            if (w_trailer_hs) begin
                r_seq <= r_seq + 16'd1;
                if (r_m_data[31] && (r_trunc_cnt != 16'hFFFF)) begin
                    r_trunc_cnt <= r_trunc_cnt + 16'd1;
                end
            end
        end
    end

    assign s_axis_tready = w_s_ready;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tlast  = r_m_last;
    assign frame_done    = w_trailer_hs;
    assign trunc_count   = r_trunc_cnt;

endmodule

// File: doc/axis_frame_trailer.md
Name: axis_frame_trailer

Overview:
- Sits directly downstream of the multi-source AXIS join arbiter, on the merged 64-bit stream headed to the DMA/host path.
- Forwards the data words unchanged, with one output register stage.
- At the end of each frame it appends one trailer word. The trailer holds a magic tag, a 16-bit frame sequence number, a truncation flag and the data-word count.
- A frame ends on input tlast, or when MAX_LEN words have been accepted, whichever comes first.

Parameters:
- DATA_WIDTH, 64, stream word width; must be >=64.
- MAX_LEN, 4096, maximum data words per frame; range 1..2^31-1.
- TRAILER_MAGIC, 16'hFEED, tag placed in trailer bits [63:48].

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- s_axis_tvalid  in  1  merged input stream valid.
- s_axis_tdata  in  DATA_WIDTH  input data.
- s_axis_tlast  in  1  end of input packet.
- s_axis_tready  out  1  input ready.
- m_axis_tvalid  out  1  output valid.
- m_axis_tdata  out  DATA_WIDTH  data word or trailer.
- m_axis_tlast  out  1  asserted only on the trailer word.
- m_axis_tready  in  1  downstream ready.
- frame_done  out  1  one-cycle pulse on the cycle the trailer handshakes.
- trunc_count  out  16  number of truncated frames, saturating at 16'hFFFF.

Behaviour:
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - frame_done=0, trunc_count=0.
  - Internal state: state=PASS, word count=0, sequence number=0.
- Reset asserted mid-frame discards the in-flight word and the partial frame. No trailer is emitted for that frame.
- Output register: a single register (valid, data, last). "Output register free" means !m_axis_tvalid || m_axis_tready.
- State PASS:
  - s_axis_tready = output register free.
  - An accepted input word loads the output register with tlast=0 and increments the count.
  - Latency is 1 cycle: a word accepted at edge N is on m_axis from cycle N+1.
- Frame end: on the accepted word where s_axis_tlast=1, or where the count reaches MAX_LEN:
  - Latch the final count.
  - Set trunc = (count==MAX_LEN) && !s_axis_tlast.
  - Go to state TRAIL.
  - If both conditions hit on the same word, trunc=0.
- State TRAIL:
  - s_axis_tready=0.
  - When the output register is free, load the trailer with tlast=1, then return to PASS and clear the count.
  - The trailer follows the last data word back-to-back when m_axis_tready stays high.
  - The input sees exactly one stall cycle per frame.
- Trailer format:
  - [63:48] TRAILER_MAGIC.
  - [47:32] sequence number.
  - [31] trunc.
  - [30:0] data-word count, zero-extended.
  - Bits above 63 are 0.
- Trailer handshake (m_axis_tvalid && m_axis_tready && m_axis_tlast):
  - frame_done=1 for that cycle.
  - Sequence number increments, wrapping 16'hFFFF -> 0.
  - If trunc was set, trunc_count increments, saturating.
- After a truncated frame, the following words start a new frame (count restarts at 1). No data is dropped or reordered.
- m_axis_tdata and m_axis_tlast hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- Empty frames cannot occur, because tlast always travels with a data word.

Test Plan:
- Single-packet pass-through:
  - Stimulus: 3-word packet A0,A1,A2 (tlast on A2), m_axis_tready=1.
  - Required: output A0,A1,A2 each with tlast=0, then trailer 64'hFEED_0000_0000_0003 with tlast=1.
  - frame_done pulses once; the next frame's trailer carries seq=1.
- Truncation (MAX_LEN=4):
  - Stimulus: 6-word packet.
  - Required: 4 words, trailer 64'hFEED_0000_8000_0004, 2 words, trailer 64'hFEED_0001_0000_0002.
  - trunc_count=1.
- Exact fit (MAX_LEN=4):
  - Stimulus: 4-word packet with tlast on word 4.
  - Required: trailer has trunc=0, count=4, and no extra frame is produced.
- Random backpressure:
  - Stimulus: m_axis_tready toggles randomly at 50% over 100 packets.
  - Required: no word lost or duplicated; outputs stable while stalled; s_axis_tready=0 in every TRAIL cycle; a scoreboard matches all counts.
- Sequence wrap:
  - Stimulus: force 65537 single-word frames, or preload the sequence number to 16'hFFFF in sim.
  - Required: trailer seq goes FFFF then 0000.
- Reset mid-frame:
  - Stimulus: assert rst after 2 of 5 words, with the output register stalled.
  - Required: next cycle m_axis_tvalid=0; the next frame's trailer has seq=0 and counts only its own words.
